tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_demux4_if.sv | 25 ++
 rtl/sat_counter.sv | 35 +++
 rtl/tdm_demux4.sv | 125 ++++++++++++
 tb/tb_tdm_demux4.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer: lock states,
// channel geometry and the sizing rule for the missing-SYNC counter.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    localparam int TDM_CHANNELS = 4;
    localparam int CH_W         = $clog2(TDM_CHANNELS);

    // The counter must be able to reach max_miss+1, the value that signals lock loss.
    function automatic int unsigned miss_cnt_width(int unsigned max_miss);
        return $clog2(max_miss + 2);
    endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial TDM input beat plus the demultiplexed frame/status outputs.
// master drives the serial beats; slave is the demultiplexer.
interface tdm_demux4_if
    import tdm_pkg::*;
();
    logic                    D;
    logic                    VALID;
    logic                    SYNC;
    logic [TDM_CHANNELS-1:0] Y;
    logic                    Y_VALID;
    logic [CH_W-1:0]         C;
    logic                    LOCKED;
    logic                    SYNC_ERR;

    modport master (
        output D, VALID, SYNC,
        input  Y, Y_VALID, C, LOCKED, SYNC_ERR
    );

    modport slave (
        input  D, VALID, SYNC,
        output Y, Y_VALID, C, LOCKED, SYNC_ERR
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned MAX   = 3,
    parameter int unsigned WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: hunts for a SYNC beat, then collects one bit per
// slot and publishes whole frames only; tolerates SYNC_MISS_MAX missing SYNCs.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned SYNC_MISS_MAX = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    tdm_demux4_if.slave bus
);
    localparam int unsigned         MISS_W     = miss_cnt_width(SYNC_MISS_MAX);
    localparam logic [MISS_W-1:0]   MISS_LIMIT = MISS_W'(SYNC_MISS_MAX);
    localparam logic [CH_W-1:0]     LAST_SLOT  = CH_W'(TDM_CHANNELS - 1);
    localparam int                  SH_W       = TDM_CHANNELS - 1;

    tdm_state_e                state_q, state_d;
    logic [CH_W-1:0]           c_q, c_d;
    logic [SH_W-1:0]           shadow_q, shadow_d;
    logic [TDM_CHANNELS-1:0]   y_q, y_d;
    logic                      y_valid_q, y_valid_d;
    logic                      sync_err_q, sync_err_d;
    logic                      miss_inc, miss_clr;
    logic [MISS_W-1:0]         miss_cnt;
    logic                      miss_ok;
    logic [SH_W-1:0]           slot_hit;

    sat_counter #(
        .MAX   (SYNC_MISS_MAX + 1),
        .WIDTH (MISS_W)
    ) u_miss_cnt (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .inc_i   (miss_inc),
        .clr_i   (miss_clr),
        .count_o (miss_cnt)
    );

    // One-hot select of the shadow bit addressed by the current slot.
    for (genvar gi = 0; gi < SH_W; gi++) begin : g_slot_hit
        assign slot_hit[gi] = (c_q == CH_W'(gi));
    end

    // New count (miss_cnt+1) stays within the limit; a zero limit never drops lock.
    assign miss_ok = (SYNC_MISS_MAX == 0) || (miss_cnt < MISS_LIMIT);

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        shadow_d   = shadow_q;
        y_d        = y_q;
        y_valid_d  = 1'b0;
        sync_err_d = 1'b0;
        miss_inc   = 1'b0;
        miss_clr   = 1'b0;

        if (bus.VALID) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.SYNC) begin
                        shadow_d[0] = bus.D;
                        c_d         = CH_W'(1);
                        miss_clr    = 1'b1;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.SYNC) begin
                        sync_err_d  = (c_q != '0);
                        shadow_d[0] = bus.D;
                        c_d         = CH_W'(1);
                        miss_clr    = 1'b1;
                    end else if (c_q == '0) begin
                        if (miss_ok) begin
                            shadow_d[0] = bus.D;
                            c_d         = CH_W'(1);
                            miss_inc    = 1'b1;
                        end else begin
                            state_d    = HUNT;
                            c_d        = '0;
                            sync_err_d = 1'b1;
                            miss_clr   = 1'b1;
                        end
                    end else if (c_q == LAST_SLOT) begin
                        y_d       = {bus.D, shadow_q};
                        y_valid_d = 1'b1;
                        c_d       = '0;
                    end else begin
                        shadow_d = (shadow_q & ~slot_hit) | ({SH_W{bus.D}} & slot_hit);
                        c_d      = c_q + 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    c_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= HUNT;
            c_q        <= '0;
            shadow_q   <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            shadow_q   <= shadow_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign bus.Y        = y_q;
    assign bus.Y_VALID  = y_valid_q;
    assign bus.C        = c_q;
    assign bus.LOCKED   = (state_q == LOCK);
    assign bus.SYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed and randomized bench for tdm_demux4 against a frame-queue reference model.
module tb_tdm_demux4;

    localparam int MISS_MAX = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    tdm_demux4_if bus ();

    tdm_demux4 #(
        .SYNC_MISS_MAX (MISS_MAX)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int n_yv_seen = 0;
    string phase  = "reset";

    // Reference model: the partial frame is a queue of received bits.
    bit         m_locked;
    bit         m_frame[$];
    int         m_miss;
    logic [3:0] m_y;
    bit         m_yv;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h, expected %0h (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_frame.delete();
        m_miss   = 0;
        m_y      = '0;
        m_yv     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit s);
        m_yv  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1'b1;
                m_frame.delete();
                m_frame.push_back(d);
                m_miss = 0;
            end
        end else if (s) begin
            if (m_frame.size() != 0) m_err = 1'b1;
            m_frame.delete();
            m_frame.push_back(d);
            m_miss = 0;
        end else if (m_frame.size() == 0) begin
            m_miss++;
            if (MISS_MAX == 0 || m_miss <= MISS_MAX) begin
                m_frame.push_back(d);
            end else begin
                m_locked = 1'b0;
                m_err    = 1'b1;
                m_miss   = 0;
            end
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
                for (int i = 0; i < 4; i++) m_y[i] = m_frame[i];
                m_yv = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    task automatic check_outputs();
        chk("Y",        bus.Y,        m_y);
        chk("Y_VALID",  bus.Y_VALID,  m_yv);
        chk("C",        bus.C,        m_locked ? m_frame.size() : 0);
        chk("LOCKED",   bus.LOCKED,   m_locked);
        chk("SYNC_ERR", bus.SYNC_ERR, m_err);
    endtask

    task automatic cycle(input bit v, input bit d, input bit s);
        @(negedge CLK);
        bus.VALID = v;
        bus.D     = d;
        bus.SYNC  = s;
        model_step(v, d, s);
        @(posedge CLK);
        #1;
        if (bus.Y_VALID === 1'b1) begin
            n_yv_seen++;
            $display("[%s] frame %0d: Y=%b C=%0d LOCKED=%b", phase, n_yv_seen, bus.Y, bus.C, bus.LOCKED);
        end
        check_outputs();
    endtask

    // Reset asserted and checked between clock edges.
    task automatic async_reset();
        @(negedge CLK);
        bus.VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        int         yv_before;
        logic [3:0] gap_bits;
        bus.D     = 1'b0;
        bus.VALID = 1'b0;
        bus.SYNC  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        #12;
        @(negedge CLK);
        RST_N = 1'b1;

        phase = "r028";
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("y_1101",  bus.Y,       4'b1101);
        chk("yv_pulse", bus.Y_VALID, 1'b1);
        chk("locked",  bus.LOCKED,  1'b1);
        cycle(0, 0, 0);
        chk("yv_drop", bus.Y_VALID, 1'b0);

        phase = "r029";
        gap_bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cycle(1, gap_bits[i], i == 0);
            if (i < 3) for (int g = 0; g < 3; g++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        chk("y_gap", bus.Y, {gap_bits[3], gap_bits[2], gap_bits[1], gap_bits[0]});

        phase = "r030";
        cycle(1, 1, 1);
        cycle(1, 0, 0);
        chk("c_at2", bus.C, 2'd2);
        cycle(1, 0, 1);
        chk("sync_err", bus.SYNC_ERR, 1'b1);
        chk("y_kept",   bus.Y,        4'b0110);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("y_resync", bus.Y, 4'b1110);

        phase = "r031";
        yv_before = n_yv_seen;
        for (int i = 0; i < 12; i++) begin
            cycle(1, $urandom_range(0, 1), 0);
            if (i == 8) begin
                chk("loss_err", bus.SYNC_ERR, 1'b1);
                chk("loss_lck", bus.LOCKED,   1'b0);
                chk("loss_c",   bus.C,        2'd0);
            end
        end
        chk("frames_delivered", n_yv_seen - yv_before, 2);

        phase = "r032";
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        chk("c_pre", bus.C, 2'd2);
        async_reset();
        cycle(1, 1, 0);
        chk("ign_c",   bus.C,      2'd0);
        chk("ign_lck", bus.LOCKED, 1'b0);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            bit v, d, s;
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                v = ($urandom_range(0, 9) < 7);
                d = $urandom_range(0, 1);
                if (m_frame.size() == 0) s = ($urandom_range(0, 1) == 0);
                else                     s = ($urandom_range(0, 19) == 0);
                cycle(v, d, s);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
